// File: rtl/mem_if_pkg.sv
// Shared definitions for the handshaked memory responders: responder states,
// bus widths and the common address-range check.
package mem_if_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        err;
        logic [29:0] word_idx;
    } addr_chk_t;

    // Byte address -> word index relative to base; flags misalignment and out-of-range.
    function automatic addr_chk_t addr_check(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] depth);
        logic [31:0] off;
        addr_chk_t   r;
        off        = addr - base;
        r.err      = (addr[1:0] != 2'b00) || (addr < base) || ({2'b00, off[31:2]} >= depth);
        r.word_idx = off[31:2];
        return r;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM: byte-enabled synchronous write, combinational read, no reset.
module mem_word_array
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: accepts one load/store at a time over valid/ready,
// inserts LATENCY wait states, then returns read data or an acknowledgement.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              cap_write;
    logic [31:0]       cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [BE_W-1:0]   cap_be;
    addr_chk_t         chk;
    logic [DATA_W-1:0] arr_rdata;
    logic              arr_en;
    logic              accept;
    logic              unused_idx;

    assign chk        = addr_check(cap_addr, BASE_ADDR, DEPTH_WORDS);
    assign accept     = req_valid && req_ready;
    assign unused_idx = ^chk.word_idx[29:AW];

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        arr_en     = 1'b0;
        resp_valid = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                req_ready = rst;
                if (req_valid && rst) begin
                    state_nx = (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Gated by rst so an asserted reset can never leave a partial write.
                arr_en   = rst;
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_be     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
                cnt       <= CNT_INIT;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ST_ACCESS) begin
                resp_err   <= chk.err;
                resp_rdata <= (chk.err || cap_write) ? '0 : arr_rdata;
            end
        end
    end

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .en   (arr_en),
        .we   (cap_write && !chk.err),
        .addr (chk.word_idx[AW-1:0]),
        .wdata(cap_wdata),
        .be   (cap_be),
        .rdata(arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (LATENCY=2 at base 0, LATENCY=0 at base 0x1000)
// driven with directed loads/stores; a monitor checks data, latency and RESP hold.
module tb_data_mem_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 0;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int dut;
        int acc;
    } lat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        busy       [2];

    int   tests    = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    lat_t lat_q[$];

    logic        prev_valid [2];
    logic        prev_hs    [2];
    logic [31:0] prev_rdata [2];
    logic        prev_err   [2];
    exp_t        mon_e;
    lat_t        mon_l;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (LAT0),
        .BASE_ADDR  (32'h0000_0000)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
    );

    data_mem_responder #(
        .DEPTH_WORDS(16),
        .LATENCY    (LAT1),
        .BASE_ADDR  (32'h0000_1000)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer a request and hold it until accepted; on accept, queue the expected response.
    task automatic do_req(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input logic [31:0] er, input logic ee, output int acc);
        int n = 0;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            tests++;
            failures++;
            $display("FAIL req_accept_timeout dut%0d addr 0x%08h: req_ready=%b, required 1", d, a, req_ready[d]);
            req_valid[d] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        exp_q.push_back('{dut: d, rdata: er, err: ee});
        lat_q.push_back('{dut: d, acc: cyc});
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || lat_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    always begin
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                prev_valid[d] = 1'b0;
                prev_hs[d]    = 1'b0;
            end else begin
                if (resp_valid[d] && !prev_valid[d]) begin
                    if (lat_q.size() == 0) begin
                        tests++;
                        failures++;
                        $display("FAIL unexpected_resp dut%0d: resp_valid=1, required 0", d);
                    end else begin
                        mon_l = lat_q.pop_front();
                        chk("resp_dut_order", d, mon_l.dut);
                        chk("resp_latency_cycle", cyc, mon_l.acc + lat_of(d) + 2);
                    end
                end
                if (resp_valid[d] && prev_valid[d] && !prev_hs[d]) begin
                    chk("hold_rdata", resp_rdata[d], prev_rdata[d]);
                    chk("hold_err", resp_err[d], prev_err[d]);
                    chk("ready_low_in_resp", req_ready[d], 0);
                end
                if (resp_valid[d] && resp_ready[d]) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        failures++;
                        $display("FAIL resp_without_request dut%0d: rdata=0x%08h", d, resp_rdata[d]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("resp_dut", d, mon_e.dut);
                        chk("resp_rdata", resp_rdata[d], mon_e.rdata);
                        chk("resp_err", resp_err[d], mon_e.err);
                        chk("busy_in_resp", busy[d], 1);
                    end
                end
                prev_valid[d] = resp_valid[d];
                prev_hs[d]    = resp_valid[d] && resp_ready[d];
                prev_rdata[d] = resp_rdata[d];
                prev_err[d]   = resp_err[d];
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a1, a2, a3, h, n;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            req_be[d]     = '0;
            resp_ready[d] = 1'b1;
            prev_valid[d] = 1'b0;
            prev_hs[d]    = 1'b0;
            prev_rdata[d] = '0;
            prev_err[d]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", req_ready[d], 0);
            chk("rst_resp_valid", resp_valid[d], 0);
            chk("rst_busy", busy[d], 0);
            chk("rst_resp_rdata", resp_rdata[d], 0);
            chk("rst_resp_err", resp_err[d], 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // LATENCY=2 responder: full word, byte-lane and empty-mask stores
        do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, a1);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, a1);
        do_req(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0, a1);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, a1);
        do_req(0, 1'b1, 32'h10, 32'h5566_7788, 4'b0000, 32'h0, 1'b0, a1);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, a1);

        // Misaligned, out of range, last valid word, and a rejected store
        do_req(0, 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, a1);
        do_req(0, 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1, a1);
        do_req(0, 1'b1, 32'h3FC, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0, a1);
        do_req(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0, a1);
        do_req(0, 1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, a1);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, a1);
        do_req(0, 1'b1, 32'h14, 32'h1122_3344, 4'hF, 32'h0, 1'b0, a1);
        drain();

        // Back-pressure: response held 5 cycles while the next request waits
        resp_ready[0] = 1'b0;
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0, a1);
        h = -100;
        fork
            do_req(0, 1'b0, 32'h14, 32'h0, 4'h0, 32'h1122_3344, 1'b0, a2);
            begin
                n = 0;
                while (!resp_valid[0] && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                repeat (5) @(negedge clk);
                h = cyc;
                resp_ready[0] = 1'b1;
            end
        join
        chk("accept_after_resp_hs", a2, h + 1);
        drain();

        // Reset during WAIT of a store must leave word 8 untouched
        do_req(0, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, a1);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, a1);
        drain();
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h1234_5678;
        req_be[0]    = 4'hF;
        req_valid[0] = 1'b1;
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("busy_in_wait", busy[0], 1);
        rst = 1'b0;
        #1;
        chk("midrst_req_ready", req_ready[0], 0);
        chk("midrst_resp_valid", resp_valid[0], 0);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_resp_rdata", resp_rdata[0], 0);
        chk("midrst_resp_err", resp_err[0], 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_req_ready", req_ready[0], 1);
        chk("post_rst_busy", busy[0], 0);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, a1);
        drain();

        // LATENCY=0 responder at base 0x1000, 16 words
        do_req(1, 1'b1, 32'h1008, 32'h0A0B_0C0D, 4'hF, 32'h0, 1'b0, a1);
        do_req(1, 1'b1, 32'h103C, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0, a1);
        do_req(1, 1'b0, 32'h1008, 32'h0, 4'h0, 32'h0A0B_0C0D, 1'b0, a1);
        do_req(1, 1'b0, 32'h103C, 32'h0, 4'h0, 32'h5A5A_5A5A, 1'b0, a2);
        do_req(1, 1'b0, 32'h1008, 32'h0, 4'h0, 32'h0A0B_0C0D, 1'b0, a3);
        chk("b2b_accept_gap_1", a2 - a1, 3);
        chk("b2b_accept_gap_2", a3 - a2, 3);
        do_req(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, 32'h0, 1'b1, a1);
        do_req(1, 1'b0, 32'h1040, 32'h0, 4'h0, 32'h0, 1'b1, a1);
        do_req(1, 1'b1, 32'h1040, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, a1);
        drain();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
